// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the E stage (shift-add multiply, restoring divide).
// Optional MD_FAST_MUL_EN: single-cycle combinational multiply; divide timing is unchanged.
`ifndef ALUOP_MULT
`define ALUOP_MULT  8'h18
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 8'h19
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   8'h1A
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  8'h1B
`endif

module md_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluopE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stallE,
  output logic        stall_md,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [31:0] opnd_r;     // multiplicand or divisor magnitude
  logic [63:0] acc_r;      // {partial product, multiplier} or {remainder, dividend/quotient}
  logic        neg_res_r;
  logic        neg_rem_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_mul_s;
  logic        is_div_s;
  logic        is_signed_s;
  logic        is_md_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic [63:0] div_next_s;
  logic        stall_s;
  logic        we_s;
`ifdef MD_FAST_MUL_EN
  logic [63:0] fast_prod_s;
`endif

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    cneg32 = neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    cneg64 = neg ? (64'd0 - v) : v;
  endfunction

  // Opcode decode and operand magnitudes for the accept cycle.
  always_comb begin
    is_mul_s    = (aluopE == `ALUOP_MULT) || (aluopE == `ALUOP_MULTU);
    is_div_s    = (aluopE == `ALUOP_DIV)  || (aluopE == `ALUOP_DIVU);
    is_signed_s = (aluopE == `ALUOP_MULT) || (aluopE == `ALUOP_DIV);
    is_md_s     = is_mul_s || is_div_s;
    mag_a_s     = cneg32(srcaE, is_signed_s & srcaE[31]);
    mag_b_s     = cneg32(srcbE, is_signed_s & srcbE[31]);
  end

  // One iteration step of the shift-add multiply and the restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    mul_next_s  = {mul_sum_s, acc_r[31:1]};
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (div_diff_s[32]) begin
      div_next_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
    end
  end

`ifdef MD_FAST_MUL_EN
  // Single-cycle multiply on magnitudes, sign restored afterwards.
  always_comb begin
    fast_prod_s = cneg64({32'd0, mag_a_s} * {32'd0, mag_b_s}, is_signed_s & (srcaE[31] ^ srcbE[31]));
  end
`endif

  // Stall request and write strobe; flush and reset force both low in the same cycle.
  always_comb begin
    stall_s = 1'b0;
    we_s    = 1'b0;
    if (!rst || flushE) begin
      stall_s = 1'b0;
      we_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: stall_s = is_md_s;
        ST_MUL:  stall_s = 1'b1;
        ST_DIV:  stall_s = 1'b1;
        ST_DONE: we_s    = ~stallE;
        default: begin
          stall_s = 1'b0;
          we_s    = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      opnd_r    <= 32'd0;
      acc_r     <= 64'd0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else if (flushE) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_md_s) begin
            neg_res_r <= is_signed_s & (srcaE[31] ^ srcbE[31]);
            neg_rem_r <= is_signed_s & srcaE[31];
            cnt_r     <= 6'd0;
            if (is_div_s && (srcbE == 32'd0)) begin
              // Divide by zero bypasses the iteration and keeps the raw dividend.
              hi_r    <= srcaE;
              lo_r    <= 32'hFFFF_FFFF;
              state_r <= ST_DONE;
            end else if (is_div_s) begin
              opnd_r  <= mag_b_s;
              acc_r   <= {32'd0, mag_a_s};
              state_r <= ST_DIV;
            end else begin
`ifdef MD_FAST_MUL_EN
              hi_r    <= fast_prod_s[63:32];
              lo_r    <= fast_prod_s[31:0];
              state_r <= ST_DONE;
`else
              opnd_r  <= mag_a_s;
              acc_r   <= {32'd0, mag_b_s};
              state_r <= ST_MUL;
`endif
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc_r <= mul_next_s;
          if (cnt_r == 6'd31) begin
            {hi_r, lo_r} <= cneg64(mul_next_s, neg_res_r);
            cnt_r        <= 6'd0;
            state_r      <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        ST_DIV: begin
          acc_r <= div_next_s;
          if (cnt_r == 6'd31) begin
            hi_r    <= cneg32(div_next_s[63:32], neg_rem_r);
            lo_r    <= cneg32(div_next_s[31:0], neg_res_r);
            cnt_r   <= 6'd0;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        ST_DONE: begin
          if (stallE) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

  assign stall_md = stall_s;
  assign hilo_we  = we_s;
  assign hi_o     = hi_r;
  assign lo_o     = lo_r;
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the MIPS pipeline. It detects MULT/MULTU/DIV/DIVU on the registered ALU opcode, latches the operands and runs the iterative datapath. It holds the pipeline with a stall request until the 64-bit result is ready, then issues a single HI/LO write strobe. It honours exception flush and downstream E-stage stall.

## Interface
- Parameters: none. Opcode encodings are the `ALUOP_MULT`, `ALUOP_MULTU`, `ALUOP_DIV` and `ALUOP_DIVU` macros from defines.vh.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- aluopE  in  8  E-stage ALU opcode.
- srcaE  in  32  rs operand: multiplicand, or dividend.
- srcbE  in  32  rt operand: multiplier, or divisor.
- flushE  in  1  E-stage flush (exception or branch). Aborts any operation.
- stallE  in  1  external E-stage stall, excluding this block's own request.
- stall_md  out  1  stall request to the hazard unit.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi_o  out  32  HI result: high product word, or remainder.
- lo_o  out  32  LO result: low product word, or quotient.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE. The state register uses a 6-bit iteration counter `cnt`.
- IDLE, when aluopE is an md op and flushE=0:
  - latch operand magnitudes, the sign flags (signed ops only) and the op type;
  - set `cnt=0`;
  - go to MUL or DIV;
  - assert stall_md combinationally in this cycle.
- IDLE with any other opcode: stay in IDLE; stall_md=0.
- MUL (iterative build): shift-add, one multiplier bit per cycle, 32 cycles with cnt 0..31. After cnt=31, go to DONE.
- DIV: restoring radix-2, one quotient bit per cycle, 32 cycles, then DONE.
- Divisor zero: detected in IDLE. Skip DIV and go straight to DONE with LO=32'hFFFF_FFFF and HI=srcaE. The raw dividend is used, with no sign fixup, for both DIV and DIVU.
- Signed fixup, applied on entry to DONE:
  - product negated if the operand signs differ;
  - quotient negated if the operand signs differ;
  - remainder takes the sign of the dividend.
- DONE:
  - stall_md=0;
  - hi_o/lo_o hold the result;
  - hilo_we = ~stallE & ~flushE;
  - if stallE=1, stay in DONE with no write; otherwise go to IDLE.
- flushE=1 in any state: next state is IDLE, hilo_we=0, stall_md=0 in that cycle. The operation is discarded.
- hi_o/lo_o hold the last result until the next DONE. They are valid only while hilo_we=1.

## Timing
- Reset values: state=IDLE, cnt=0, stall_md=0, hilo_we=0, hi_o=0, lo_o=0, busy=0, all internal operand registers 0.
- Reset asserted mid-operation: immediate return to IDLE, no write.
- Let S be the cycle in which the op is accepted. stall_md is high from S through S+32 inclusive (33 cycles). DONE is S+33, where hilo_we=1 provided stallE=0.
- Divide by zero: stall_md high in S only; DONE at S+1.
- The md instruction leaves E at the end of DONE. No restart is possible, because IDLE is entered only after E advances.
- Back-to-back md ops: the second op is accepted in the cycle after DONE.
- stall_md never depends on stallE. flushE overrides stall_md in the same cycle.

## Configuration
- MD_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational 32x32 multiply, then the signed result is registered at S;
  - DONE at S+1, stall_md high in S only;
  - DIV/DIVU timing unchanged.
- MD_FAST_MUL_EN undefined: iterative MUL path, 33 stall cycles as above.

## Test plan
- MULT, srcaE=32'hFFFF_FFFD (-3), srcbE=7 -> hilo_we once, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB. Stall length 33 cycles, or 1 cycle with MD_FAST_MUL_EN.
- MULTU, 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- Signed and unsigned divides:
  - DIV -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF;
  - DIVU 100/7 -> LO=14, HI=2, stall_md high for exactly 33 cycles;
  - DIVU 5/0 -> LO=32'hFFFF_FFFF, HI=5, DONE at S+1.
- DIVU 100/7, with flushE pulsed at S+10 -> no hilo_we, busy=0 at S+11. A following MULTU 3x4 gives LO=12, HI=0.
- DIV with stallE held high for 3 cycles in DONE -> hilo_we=0 for those cycles, then exactly one hilo_we pulse. No restart afterwards.
- rst driven low at S+5 of a DIV -> all outputs 0 while rst is low. After release, the next MULTU completes normally.
